// File: rtl/bus_target_8088.sv
// bus_target_8088: 8088 minimum-mode bus target that serves one memory or I/O window
// from internal byte storage and stretches accesses with programmable wait states.
module bus_target_8088 #(
  parameter int                ADDR_W      = 20,
  parameter int                DATA_W      = 8,
  parameter logic [ADDR_W-1:0] BASE        = '0,
  parameter int                DEPTH       = 256,
  parameter bit                IS_IO       = 1'b0,
  parameter int                WAIT_STATES = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ALE,
  input  logic [ADDR_W-1:0] Address,
  input  logic              IOM,
  input  logic              RD,
  input  logic              WR,
  inout  wire  [DATA_W-1:0] Data,
  output logic              READY,
  output logic              SEL,
  output logic              ERR
);
  localparam int off_w = $clog2(DEPTH);
  localparam logic [ADDR_W:0] depth_x = (ADDR_W + 1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, ADDR, RDACC, WRACC} state_t;
  state_t state, state_n;
  logic [off_w-1:0] off;
  logic [3:0] cnt;
  logic [DATA_W-1:0] wbuf;
  logic wvalid;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0] rel;
  logic hit, both, acc, drive, commit;
  // One extra bit makes addresses below BASE wrap far above DEPTH, so a single compare decodes.
  assign rel = {1'b0, Address} - {1'b0, BASE};
  assign hit = (IOM == IS_IO) && rel < depth_x;
  assign both = !RD && !WR;
  assign acc = state == RDACC || state == WRACC;
  assign commit = !ALE && state == WRACC && WR && cnt == 4'd0 && wvalid;
  assign Data = drive ? mem[off] : 'z;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (ALE) state_n = hit ? ADDR : IDLE;
    else if (state == ADDR) state_n = both ? IDLE : !RD ? RDACC : !WR ? WRACC : ADDR;
    else if (state == RDACC) state_n = (RD || !WR) ? IDLE : RDACC;
    else if (state == WRACC) state_n = (WR || !RD) ? IDLE : WRACC;
  end
  always_comb begin
    READY = !(acc && cnt != 4'd0);
    SEL = state != IDLE;
    drive = state == RDACC && !RD;
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      off <= '0;
      cnt <= '0;
      wbuf <= '0;
      wvalid <= 1'b0;
      ERR <= 1'b0;
    end else if (ALE) begin
      off <= rel[off_w-1:0];
      wvalid <= 1'b0;
    end else begin
      if (state == ADDR && RD != WR) cnt <= 4'(WAIT_STATES);
      else if (acc && cnt != 4'd0) cnt <= cnt - 4'd1;
      if ((state != IDLE && both) || (state == WRACC && WR && cnt != 4'd0)) ERR <= 1'b1;
      if (state == WRACC && !WR && RD && cnt == 4'd0) begin
        wbuf <= Data;
        wvalid <= 1'b1;
      end else if (state == WRACC) wvalid <= 1'b0;
    end
  always_ff @(posedge CLK)
    if (commit) mem[off] <= wbuf;
endmodule
